snake_sequencer: RTL and testbench
==================================

Name: snake_sequencer

Overview:
- Parametrised successor to the snake game's master control FSM.
- Sequences title wait, body setup, per-part drawing, apple drawing, body shift/movement and trail erase.
- Owns the body RAM address counter, snake length register and pixel-draw counter.
- New over the previous generation:
  - configurable cell size, initial length, growth step and maximum length
  - growth queued and applied only between frames
  - pause mode
  - win pulse when the length saturates

Parameters:
- LEN_W, 9: width of length, body counter and ram_addr.
- INIT_LEN, 3: length after reset or death; must be 1 to MAX_LEN.
- GROW, 3: parts added per apple hit.
- MAX_LEN, 256: maximum length; must be at most 2**LEN_W - 1.
- CELL_PX, 16: draw cycles per cell; must be a power of two and at least 2.
- PX_W, $clog2(CELL_PX): width of draw_status.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous active-low reset.
- title_done  in  1  title screen finished.
- tick  in  1  movement tick (one-cycle pulse).
- pause  in  1  level, freeze game at the next tick boundary.
- has_collided  in  1  head hit apple (one-cycle pulse, any state).
- is_dead  in  1  snake died.
- ram_addr  out  LEN_W  body RAM address.
- load_default_head, load_part_into_ram, load_ram_into_current, draw_ram, draw_apple, erase_trail  out  1 each  datapath strobes.
- update_head, inc_check, load_head_into_prev, load_prev_into_ram, load_current_into_prev, reset_ram  out  1 each  datapath strobes.
- draw_status  out  PX_W  pixel index within the cell.
- snake_len  out  LEN_W  current length.
- max_reached  out  1  one-cycle pulse when the length reaches MAX_LEN.

Behaviour:
- Reset (sampled at clk edge while reset=0):
  - state=TITLE, ram_addr=0, body_cnt=0, px_cnt=0, snake_len=INIT_LEN, pending=0.
  - All strobes 0, draw_status=0, max_reached=0.
- Outputs are a Moore decode of state; all are 0 by default.
- draw_status = px_cnt in DRAW_PART, APPLE and ERASE; 0 otherwise.
- State transitions:
  - TITLE: asserts reset_ram; ram_addr increments each cycle (clears the RAM) and wraps. If title_done -> SETUP_HEAD.
  - SETUP_HEAD: load_default_head; ram_addr<=0; body_cnt<=0 -> SETUP_WRITE.
  - SETUP_WRITE: load_part_into_ram -> SETUP_WAIT -> SETUP_INC.
  - SETUP_INC: ram_addr++, body_cnt++. If body_cnt < snake_len-1 -> SETUP_WRITE, else -> SETUP_DONE.
  - SETUP_DONE: clear addr and counters -> DRAW_LOAD.
  - DRAW_LOAD: load_ram_into_current -> DRAW_PART.
  - DRAW_PART: draw_ram; px_cnt++. Stays for exactly CELL_PX cycles, leaving when px_cnt = CELL_PX-1 -> DRAW_INC.
  - DRAW_INC: addr/body_cnt++, px_cnt<=0. Same loop test -> DRAW_LOAD or DRAW_DONE.
  - DRAW_DONE: clear -> APPLE.
  - APPLE: draw_apple for CELL_PX cycles -> APPLE_DONE -> MOV_HEAD.
  - MOV_HEAD: update_head -> MOV_CHECK.
  - MOV_CHECK: inc_check -> MOV_HPREV.
  - MOV_HPREV: load_head_into_prev -> MOV_READ.
  - MOV_READ: load_ram_into_current -> MOV_WRITE.
  - MOV_WRITE: load_prev_into_ram -> MOV_WAIT -> MOV_SHIFT.
  - MOV_SHIFT: load_current_into_prev; addr/body_cnt++. If loop test -> MOV_SWAIT -> MOV_READ, else -> MOV_DONE.
  - MOV_DONE: clear counters; apply growth -> WAIT_TICK.
  - WAIT_TICK: if pause -> PAUSED; else if tick -> ERASE.
  - PAUSED: all strobes 0; a tick is ignored. If !pause -> WAIT_TICK.
  - ERASE: erase_trail for CELL_PX cycles -> SETUP_DONE.
- Loop test uses body_cnt < snake_len-1, computed in LEN_W+1 bits. The loop runs exactly snake_len iterations; snake_len=1 gives a single iteration.
- Growth:
  - has_collided adds GROW to pending, saturating at MAX_LEN.
  - At MOV_DONE only: snake_len <= min(snake_len+pending, MAX_LEN); pending<=0. A hit in the same cycle as MOV_DONE is carried into the new pending.
  - max_reached pulses in the cycle after MOV_DONE if snake_len was below MAX_LEN and is now equal to it.
  - The length never changes mid-frame, so the draw and shift loops see a stable bound.
- Death:
  - is_dead in any state: next state TITLE; snake_len<=INIT_LEN; pending<=0; counters cleared at the next edge.
  - is_dead overrides tick, pause and has_collided. Reset overrides everything.
- Unused encodings -> TITLE.

Decomposition:
- Package snake_pkg holds:
  - the state enum (5-bit localparams, ordering as listed)
  - the default parameter constants: INIT_LEN, GROW and CELL_PX.
- One sub-module, snake_len_ctrl: pending accumulator, saturating length update, max_reached pulse.
- The FSM and counters stay in snake_sequencer.

Test Plan:
- Defaults with CELL_PX=16, INIT_LEN=3. Reset, title_done at cycle 5, then:
  - SETUP_WRITE 3 times with ram_addr 0,1,2;
  - draw_ram 48 cycles total, draw_status sweeping 0..15 three times;
  - draw_apple 16 cycles;
  - then WAIT_TICK.
- Shift pass at length 3: load_prev_into_ram at ram_addr 0,1,2 in order; WAIT_TICK is reached without a tick. A tick then gives erase_trail for 16 cycles, then a redraw.
- has_collided pulsed during DRAW_PART: snake_len stays 3 through the frame, becomes 6 after MOV_DONE; the next draw shows 6 parts (96 draw_ram cycles).
- MAX_LEN=8, GROW=3, INIT_LEN=3:
  - two hits give len 8 and a single max_reached pulse;
  - a third hit leaves len 8 with no further pulse.
- pause held entering WAIT_TICK, tick pulsed 3 times: stays PAUSED with no strobes. Dropping pause returns to WAIT_TICK; the next tick gives ERASE.
- is_dead mid-DRAW_PART, and separately reset=0 mid-MOV_SHIFT: TITLE next cycle, snake_len=3, pending cleared, reset_ram asserted.

Source files
------------

// File: rtl/snake_pkg.sv
// Shared state encoding and default parameters for the snake game sequencer.
package snake_pkg;

    localparam int DEF_INIT_LEN = 3;
    localparam int DEF_GROW     = 3;
    localparam int DEF_CELL_PX  = 16;

    typedef enum logic [4:0] {
        S_TITLE       = 5'd0,
        S_SETUP_HEAD  = 5'd1,
        S_SETUP_WRITE = 5'd2,
        S_SETUP_WAIT  = 5'd3,
        S_SETUP_INC   = 5'd4,
        S_SETUP_DONE  = 5'd5,
        S_DRAW_LOAD   = 5'd6,
        S_DRAW_PART   = 5'd7,
        S_DRAW_INC    = 5'd8,
        S_DRAW_DONE   = 5'd9,
        S_APPLE       = 5'd10,
        S_APPLE_DONE  = 5'd11,
        S_MOV_HEAD    = 5'd12,
        S_MOV_CHECK   = 5'd13,
        S_MOV_HPREV   = 5'd14,
        S_MOV_READ    = 5'd15,
        S_MOV_WRITE   = 5'd16,
        S_MOV_WAIT    = 5'd17,
        S_MOV_SHIFT   = 5'd18,
        S_MOV_SWAIT   = 5'd19,
        S_MOV_DONE    = 5'd20,
        S_WAIT_TICK   = 5'd21,
        S_PAUSED      = 5'd22,
        S_ERASE       = 5'd23
    } state_t;

endpackage

// File: rtl/snake_len_ctrl.sv
// Snake length bookkeeping: queues growth from apple hits and commits it
// only at the frame boundary so the draw/shift loops see a stable bound.
module snake_len_ctrl #(
    parameter int LEN_W    = 9,
    parameter int INIT_LEN = 3,
    parameter int GROW     = 3,
    parameter int MAX_LEN  = 256
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             hit,
    input  logic             apply,
    input  logic             kill,
    output logic [LEN_W-1:0] snake_len,
    output logic             max_reached
);

    // Two spare bits so len+pending and pending+GROW cannot overflow.
    localparam int SUM_W = LEN_W + 2;
    localparam logic [SUM_W-1:0] MAX_S    = SUM_W'(MAX_LEN);
    localparam logic [SUM_W-1:0] GROW_S   = SUM_W'(GROW);
    localparam logic [SUM_W-1:0] GROW_SAT = (GROW_S > MAX_S) ? MAX_S : GROW_S;

    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] pend_q, pend_d;
    logic             max_q, max_d;
    logic [SUM_W-1:0] pend_sum, len_sum;

    function automatic logic [SUM_W-1:0] sat(input logic [SUM_W-1:0] v);
        return (v > MAX_S) ? MAX_S : v;
    endfunction

    // Pending accumulation, frame-boundary commit and saturation pulse.
    always_comb begin
        pend_sum = sat(SUM_W'(pend_q) + GROW_S);
        len_sum  = sat(SUM_W'(len_q) + SUM_W'(pend_q));
        len_d    = len_q;
        pend_d   = pend_q;
        max_d    = 1'b0;
        if (kill) begin
            len_d  = LEN_W'(INIT_LEN);
            pend_d = '0;
        end else if (apply) begin
            len_d  = len_sum[LEN_W-1:0];
            // A hit landing on the commit cycle starts the next batch.
            pend_d = hit ? GROW_SAT[LEN_W-1:0] : '0;
            max_d  = (SUM_W'(len_q) < MAX_S) && (len_sum == MAX_S);
        end else if (hit) begin
            pend_d = pend_sum[LEN_W-1:0];
        end
    end

    // Length state registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            len_q  <= LEN_W'(INIT_LEN);
            pend_q <= '0;
            max_q  <= 1'b0;
        end else begin
            len_q  <= len_d;
            pend_q <= pend_d;
            max_q  <= max_d;
        end
    end

    assign snake_len   = len_q;
    assign max_reached = max_q;

endmodule

// File: rtl/snake_sequencer.sv
// Master control FSM for the snake game: title, body setup, per-part draw,
// apple draw, body shift and trail erase, plus the address/pixel counters.
module snake_sequencer import snake_pkg::*; #(
    parameter int LEN_W    = 9,
    parameter int INIT_LEN = DEF_INIT_LEN,
    parameter int GROW     = DEF_GROW,
    parameter int MAX_LEN  = 256,
    parameter int CELL_PX  = DEF_CELL_PX,
    parameter int PX_W     = $clog2(CELL_PX)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             title_done,
    input  logic             tick,
    input  logic             pause,
    input  logic             has_collided,
    input  logic             is_dead,
    output logic [LEN_W-1:0] ram_addr,
    output logic             load_default_head,
    output logic             load_part_into_ram,
    output logic             load_ram_into_current,
    output logic             draw_ram,
    output logic             draw_apple,
    output logic             erase_trail,
    output logic             update_head,
    output logic             inc_check,
    output logic             load_head_into_prev,
    output logic             load_prev_into_ram,
    output logic             load_current_into_prev,
    output logic             reset_ram,
    output logic [PX_W-1:0]  draw_status,
    output logic [LEN_W-1:0] snake_len,
    output logic             max_reached
);

    state_t           state_q, state_d;
    logic [LEN_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0] body_q, body_d;
    logic [PX_W-1:0]  px_q, px_d;
    logic [LEN_W:0]   len_m1;
    logic             loop_more;
    logic             px_last;

    snake_len_ctrl #(
        .LEN_W    (LEN_W),
        .INIT_LEN (INIT_LEN),
        .GROW     (GROW),
        .MAX_LEN  (MAX_LEN)
    ) u_len (
        .clk         (clk),
        .reset       (reset),
        .hit         (has_collided),
        .apply       (state_q == S_MOV_DONE),
        .kill        (is_dead),
        .snake_len   (snake_len),
        .max_reached (max_reached)
    );

    // Loop bound compared one bit wider so snake_len=1 yields a single pass.
    always_comb begin
        len_m1    = {1'b0, snake_len} - (LEN_W+1)'(1);
        loop_more = ({1'b0, body_q} < len_m1);
        px_last   = (px_q == PX_W'(CELL_PX - 1));
    end

    // Next-state and counter updates; death forces TITLE with clean counters.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        body_d  = body_q;
        px_d    = px_q;
        case (state_q)
            S_TITLE: begin
                addr_d = addr_q + LEN_W'(1);
                if (title_done) state_d = S_SETUP_HEAD;
            end
            S_SETUP_HEAD: begin
                addr_d  = '0;
                body_d  = '0;
                state_d = S_SETUP_WRITE;
            end
            S_SETUP_WRITE: state_d = S_SETUP_WAIT;
            S_SETUP_WAIT:  state_d = S_SETUP_INC;
            S_SETUP_INC: begin
                addr_d  = addr_q + LEN_W'(1);
                body_d  = body_q + LEN_W'(1);
                state_d = loop_more ? S_SETUP_WRITE : S_SETUP_DONE;
            end
            S_SETUP_DONE: begin
                addr_d  = '0;
                body_d  = '0;
                px_d    = '0;
                state_d = S_DRAW_LOAD;
            end
            S_DRAW_LOAD: state_d = S_DRAW_PART;
            S_DRAW_PART: begin
                px_d = px_q + PX_W'(1);
                if (px_last) state_d = S_DRAW_INC;
            end
            S_DRAW_INC: begin
                addr_d  = addr_q + LEN_W'(1);
                body_d  = body_q + LEN_W'(1);
                px_d    = '0;
                state_d = loop_more ? S_DRAW_LOAD : S_DRAW_DONE;
            end
            S_DRAW_DONE: begin
                addr_d  = '0;
                body_d  = '0;
                px_d    = '0;
                state_d = S_APPLE;
            end
            S_APPLE: begin
                px_d = px_q + PX_W'(1);
                if (px_last) state_d = S_APPLE_DONE;
            end
            S_APPLE_DONE: begin
                px_d    = '0;
                state_d = S_MOV_HEAD;
            end
            S_MOV_HEAD:  state_d = S_MOV_CHECK;
            S_MOV_CHECK: state_d = S_MOV_HPREV;
            S_MOV_HPREV: state_d = S_MOV_READ;
            S_MOV_READ:  state_d = S_MOV_WRITE;
            S_MOV_WRITE: state_d = S_MOV_WAIT;
            S_MOV_WAIT:  state_d = S_MOV_SHIFT;
            S_MOV_SHIFT: begin
                addr_d  = addr_q + LEN_W'(1);
                body_d  = body_q + LEN_W'(1);
                state_d = loop_more ? S_MOV_SWAIT : S_MOV_DONE;
            end
            S_MOV_SWAIT: state_d = S_MOV_READ;
            S_MOV_DONE: begin
                addr_d  = '0;
                body_d  = '0;
                px_d    = '0;
                state_d = S_WAIT_TICK;
            end
            S_WAIT_TICK: begin
                if (pause)     state_d = S_PAUSED;
                else if (tick) state_d = S_ERASE;
            end
            S_PAUSED: begin
                if (!pause) state_d = S_WAIT_TICK;
            end
            S_ERASE: begin
                px_d = px_q + PX_W'(1);
                if (px_last) state_d = S_SETUP_DONE;
            end
            default: begin
                state_d = S_TITLE;
                addr_d  = '0;
                body_d  = '0;
                px_d    = '0;
            end
        endcase
        if (is_dead) begin
            state_d = S_TITLE;
            addr_d  = '0;
            body_d  = '0;
            px_d    = '0;
        end
    end

    // State and counter registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_TITLE;
            addr_q  <= '0;
            body_q  <= '0;
            px_q    <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            body_q  <= body_d;
            px_q    <= px_d;
        end
    end

    // Moore decode of the datapath strobes.
    always_comb begin
        load_default_head      = 1'b0;
        load_part_into_ram     = 1'b0;
        load_ram_into_current  = 1'b0;
        draw_ram               = 1'b0;
        draw_apple             = 1'b0;
        erase_trail            = 1'b0;
        update_head            = 1'b0;
        inc_check              = 1'b0;
        load_head_into_prev    = 1'b0;
        load_prev_into_ram     = 1'b0;
        load_current_into_prev = 1'b0;
        reset_ram              = 1'b0;
        draw_status            = '0;
        case (state_q)
            S_TITLE:       reset_ram = 1'b1;
            S_SETUP_HEAD:  load_default_head = 1'b1;
            S_SETUP_WRITE: load_part_into_ram = 1'b1;
            S_DRAW_LOAD:   load_ram_into_current = 1'b1;
            S_DRAW_PART: begin
                draw_ram    = 1'b1;
                draw_status = px_q;
            end
            S_APPLE: begin
                draw_apple  = 1'b1;
                draw_status = px_q;
            end
            S_MOV_HEAD:    update_head = 1'b1;
            S_MOV_CHECK:   inc_check = 1'b1;
            S_MOV_HPREV:   load_head_into_prev = 1'b1;
            S_MOV_READ:    load_ram_into_current = 1'b1;
            S_MOV_WRITE:   load_prev_into_ram = 1'b1;
            S_MOV_SHIFT:   load_current_into_prev = 1'b1;
            S_ERASE: begin
                erase_trail = 1'b1;
                draw_status = px_q;
            end
            default: ;
        endcase
    end

    assign ram_addr = addr_q;

endmodule

// File: tb/tb_snake_sequencer.sv
// Directed bench for snake_sequencer: a reset/title/setup vector table, then
// whole-frame observations and hand-written corner sequences.
module tb_snake_sequencer;

    localparam int LEN_W = 9;
    localparam int PX_W  = 4;

    // Strobe bundle bit positions.
    localparam logic [11:0] B_RR  = 12'h800;
    localparam logic [11:0] B_LDH = 12'h400;
    localparam logic [11:0] B_LPR = 12'h200;
    localparam logic [11:0] B_LRC = 12'h100;
    localparam logic [11:0] B_DR  = 12'h080;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             title_done = 1'b0, tick = 1'b0, pause = 1'b0;
    logic             has_collided = 1'b0, is_dead = 1'b0;
    logic [LEN_W-1:0] ram_addr, snake_len;
    logic [PX_W-1:0]  draw_status;
    logic load_default_head, load_part_into_ram, load_ram_into_current, draw_ram;
    logic draw_apple, erase_trail, update_head, inc_check, load_head_into_prev;
    logic load_prev_into_ram, load_current_into_prev, reset_ram, max_reached;

    int n_checks = 0;
    int n_fail   = 0;

    // Defaults except MAX_LEN=8, so saturation is reachable in a few frames.
    snake_sequencer #(.LEN_W(LEN_W), .INIT_LEN(3), .GROW(3), .MAX_LEN(8), .CELL_PX(16)) dut (
        .clk(clk), .reset(reset), .title_done(title_done), .tick(tick), .pause(pause),
        .has_collided(has_collided), .is_dead(is_dead), .ram_addr(ram_addr),
        .load_default_head(load_default_head), .load_part_into_ram(load_part_into_ram),
        .load_ram_into_current(load_ram_into_current), .draw_ram(draw_ram),
        .draw_apple(draw_apple), .erase_trail(erase_trail), .update_head(update_head),
        .inc_check(inc_check), .load_head_into_prev(load_head_into_prev),
        .load_prev_into_ram(load_prev_into_ram), .load_current_into_prev(load_current_into_prev),
        .reset_ram(reset_ram), .draw_status(draw_status), .snake_len(snake_len),
        .max_reached(max_reached)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    function automatic logic [11:0] strobes();
        return {reset_ram, load_default_head, load_part_into_ram, load_ram_into_current,
                draw_ram, draw_apple, update_head, inc_check, load_head_into_prev,
                load_prev_into_ram, load_current_into_prev, erase_trail};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Runs until the sequencer has been idle for 6 cycles and checks the frame totals.
    task automatic run_frame(input string tag, input bit t_first, input bit td_first,
                             input bit hit_en, input int len_frame, input int len_end,
                             input int exp_max, input int exp_erase, input int exp_writes);
        int cyc = 0, quiet = 0;
        int n_draw = 0, n_apple = 0, n_erase = 0, n_write = 0, n_max = 0;
        int bad_px = 0, bad_len = 0, bad_order = 0;
        int lpr_q[$];
        tick = t_first;
        title_done = td_first;
        has_collided = 1'b0;
        while (quiet < 6 && cyc < 3000) begin
            step();
            cyc++;
            tick = 1'b0;
            title_done = 1'b0;
            has_collided = 1'b0;
            if (strobes() == 12'h0) quiet++; else quiet = 0;
            if (max_reached) n_max++;
            if (draw_ram) begin
                if (int'(draw_status) != n_draw % 16 || int'(ram_addr) != n_draw / 16) bad_px++;
                if (int'(snake_len) != len_frame) bad_len++;
                if (hit_en && n_draw == 5) has_collided = 1'b1;
                n_draw++;
            end else if (draw_apple) begin
                if (int'(draw_status) != n_apple % 16) bad_px++;
                n_apple++;
            end else if (erase_trail) begin
                if (int'(draw_status) != n_erase % 16) bad_px++;
                n_erase++;
            end else if (draw_status != '0) begin
                bad_px++;
            end
            if (load_part_into_ram) n_write++;
            if (load_prev_into_ram) begin
                lpr_q.push_back(int'(ram_addr));
                if (int'(snake_len) != len_frame) bad_len++;
            end
        end
        if (lpr_q.size() != len_frame) bad_order++;
        foreach (lpr_q[i]) if (lpr_q[i] != i) bad_order++;
        check({tag, "_reached_idle"}, (quiet >= 6), 1);
        check({tag, "_setup_writes"}, n_write, exp_writes);
        check({tag, "_erase_cycles"}, n_erase, exp_erase);
        check({tag, "_draw_cycles"}, n_draw, 16 * len_frame);
        check({tag, "_apple_cycles"}, n_apple, 16);
        check({tag, "_draw_status_addr"}, bad_px, 0);
        check({tag, "_shift_order"}, bad_order, 0);
        check({tag, "_len_stable"}, bad_len, 0);
        check({tag, "_len_end"}, snake_len, len_end);
        check({tag, "_max_pulses"}, n_max, exp_max);
    endtask

    typedef struct {
        bit          rst_n;
        bit          td;
        logic [11:0] strb;
        int          addr;
        int          len;
    } vec_t;

    vec_t vecs[17];

    initial begin
        int bad;
        // Reset, five title cycles (address sweeps), title_done, setup of 3 parts.
        vecs[0]  = '{0, 0, B_RR,  0, 3};
        vecs[1]  = '{1, 0, B_RR,  1, 3};
        vecs[2]  = '{1, 0, B_RR,  2, 3};
        vecs[3]  = '{1, 0, B_RR,  3, 3};
        vecs[4]  = '{1, 0, B_RR,  4, 3};
        vecs[5]  = '{1, 1, B_LDH, 5, 3};
        vecs[6]  = '{1, 0, B_LPR, 0, 3};
        vecs[7]  = '{1, 0, 12'h0, 0, 3};
        vecs[8]  = '{1, 0, 12'h0, 0, 3};
        vecs[9]  = '{1, 0, B_LPR, 1, 3};
        vecs[10] = '{1, 0, 12'h0, 1, 3};
        vecs[11] = '{1, 0, 12'h0, 1, 3};
        vecs[12] = '{1, 0, B_LPR, 2, 3};
        vecs[13] = '{1, 0, 12'h0, 2, 3};
        vecs[14] = '{1, 0, 12'h0, 2, 3};
        vecs[15] = '{1, 0, 12'h0, 3, 3};
        vecs[16] = '{1, 0, B_LRC, 0, 3};

        for (int i = 0; i < 17; i++) begin
            reset = vecs[i].rst_n;
            title_done = vecs[i].td;
            step();
            check($sformatf("vec%0d_strobes", i), strobes(), vecs[i].strb);
            check($sformatf("vec%0d_addr", i), ram_addr, vecs[i].addr);
            check($sformatf("vec%0d_len", i), snake_len, vecs[i].len);
            check($sformatf("vec%0d_status", i), draw_status, 0);
            if (i == 0) check("reset_max", max_reached, 0);
        end
        title_done = 1'b0;

        // First draw + shift, no tick needed to reach WAIT_TICK.
        run_frame("f1", 0, 0, 0, 3, 3, 0, 0, 0);
        // Hit mid-draw: length holds at 3 for the frame, becomes 6 after.
        run_frame("f2_hit", 1, 0, 1, 3, 6, 0, 16, 0);
        // Second hit saturates at 8 with one max pulse.
        run_frame("f3_hit", 1, 0, 1, 6, 8, 1, 16, 0);
        // Further hit stays at 8, no pulse.
        run_frame("f4_sat", 1, 0, 1, 8, 8, 0, 16, 0);

        // Pause: ticks ignored, no strobes until pause drops.
        pause = 1'b1;
        step();
        check("paused_quiet", strobes(), 0);
        bad = 0;
        for (int i = 0; i < 9; i++) begin
            tick = (i % 3 == 0);
            step();
            if (strobes() != 12'h0 || draw_status != '0) bad++;
        end
        tick = 1'b0;
        check("pause_ticks_ignored", bad, 0);
        pause = 1'b0;
        step();
        check("unpause_quiet", strobes(), 0);
        run_frame("after_pause", 1, 0, 0, 8, 8, 0, 16, 0);

        // Death mid-DRAW_PART right after a hit.
        tick = 1'b1;
        step();
        tick = 1'b0;
        for (int i = 0; i < 500 && !(draw_ram && draw_status == 4'd3); i++) step();
        check("dead_reach_draw", (draw_ram && draw_status == 4'd3), 1);
        has_collided = 1'b1;
        step();
        has_collided = 1'b0;
        is_dead = 1'b1;
        step();
        is_dead = 1'b0;
        check("dead_strobes", strobes(), B_RR);
        check("dead_addr", ram_addr, 0);
        check("dead_len", snake_len, 3);
        check("dead_status", draw_status, 0);
        run_frame("revive", 0, 1, 0, 3, 3, 0, 0, 3);

        // Reset mid-MOV_SHIFT after a queued hit.
        tick = 1'b1;
        step();
        tick = 1'b0;
        for (int i = 0; i < 500 && !(draw_ram && draw_status == 4'd3); i++) step();
        has_collided = 1'b1;
        step();
        has_collided = 1'b0;
        for (int i = 0; i < 500 && !load_current_into_prev; i++) step();
        check("rst_reach_shift", load_current_into_prev, 1);
        reset = 1'b0;
        step();
        check("rst_strobes", strobes(), B_RR);
        check("rst_addr", ram_addr, 0);
        check("rst_len", snake_len, 3);
        check("rst_max", max_reached, 0);
        reset = 1'b1;
        run_frame("post_rst", 0, 1, 0, 3, 3, 0, 0, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
